mul_seq: RTL

- Sequential shift-and-add unsigned multiplier for the calculator datapath; it is the multiplicative counterpart of the sequential restoring divider.
- Processes one multiplier bit per clock and produces the full 2*BITS-bit product.
- Uses the same input_vld/output_vld handshake as the divider, so the calc controller drives both blocks the same way.

---
 rtl/calc_pkg.sv | 10 +
 rtl/mul_seq_if.sv | 17 +
 rtl/mul_step.sv | 18 +
 rtl/mul_seq.sv | 95 +++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared calculator datapath definitions: bit-index width, state encoding, default operand width.
package calc_pkg;
  localparam int IDX_W    = 5;
  localparam int BITS_DEF = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;
endpackage

// File: rtl/mul_seq_if.sv
// Operand/product handshake bundle for mul_seq; MUL_OVF_EN adds the ovf flag.
interface mul_seq_if #(parameter int BITS = calc_pkg::BITS_DEF);
  logic [BITS-1:0]   A;
  logic [BITS-1:0]   B;
  logic [2*BITS-1:0] P;
  logic              input_vld;
  logic              output_vld;
`ifdef MUL_OVF_EN
  logic              ovf;

  modport master (output A, B, input_vld, input P, output_vld, ovf);
  modport slave  (input A, B, input_vld, output P, output_vld, ovf);
`else
  modport master (output A, B, input_vld, input P, output_vld);
  modport slave  (input A, B, input_vld, output P, output_vld);
`endif
endinterface

// File: rtl/mul_step.sv
// One shift-and-add step: conditionally adds the multiplicand, shifted by idx, to the accumulator.
module mul_step
  import calc_pkg::*;
#(
  parameter int BITS = BITS_DEF
) (
  input  logic [2*BITS-1:0] acc_in,
  input  logic [BITS-1:0]   a,
  input  logic              b_bit,
  input  logic [IDX_W-1:0]  idx,
  output logic [2*BITS-1:0] acc_out
);
  logic [2*BITS-1:0] a_ext;

  assign a_ext   = {{BITS{1'b0}}, a};
  // Product of two BITS-wide values fits in 2*BITS, so this sum never wraps.
  assign acc_out = b_bit ? acc_in + (a_ext << idx) : acc_in;
endmodule

// File: rtl/mul_seq.sv
// Sequential shift-and-add unsigned multiplier, one multiplier bit per clock, fixed BITS+1 edge latency.
// Optional MUL_OVF_EN adds a registered flag set when the product exceeds BITS bits.
module mul_seq
  import calc_pkg::*;
#(
  parameter int BITS = BITS_DEF
) (
  input  logic      clk,
  input  logic      rst_n,
  mul_seq_if.slave  bus
);
  localparam int PW = 2 * BITS;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  bitidx_q, bitidx_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [BITS-1:0]   a_q, a_d;
  logic [BITS-1:0]   b_q, b_d;
  logic [PW-1:0]     step_acc;
  logic [BITS-1:0]   b_shift;
`ifdef MUL_OVF_EN
  logic              ovf_q, ovf_d;
`endif

  assign b_shift = b_q >> bitidx_q;

  mul_step #(.BITS(BITS)) u_step (
    .acc_in  (acc_q),
    .a       (a_q),
    .b_bit   (b_shift[0]),
    .idx     (bitidx_q),
    .acc_out (step_acc)
  );

  always_comb begin
    state_d  = state_q;
    bitidx_d = bitidx_q;
    acc_d    = acc_q;
    a_d      = a_q;
    b_d      = b_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.input_vld) begin
          a_d      = bus.A;
          b_d      = bus.B;
          acc_d    = '0;
          bitidx_d = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_d = step_acc;
        if (bitidx_q == IDX_W'(BITS - 1)) begin
          bitidx_d = '0;
          state_d  = ST_IDLE;
        end else begin
          bitidx_d = bitidx_q + IDX_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef MUL_OVF_EN
    ovf_d = |acc_d[PW-1:BITS];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      bitidx_q <= '0;
      acc_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
`ifdef MUL_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      bitidx_q <= bitidx_d;
      acc_q    <= acc_d;
      a_q      <= a_d;
      b_q      <= b_d;
`ifdef MUL_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  // P exposes partial sums while running; consumers qualify it with output_vld.
  assign bus.P          = acc_q;
  assign bus.output_vld = (state_q == ST_IDLE);
`ifdef MUL_OVF_EN
  assign bus.ovf        = ovf_q;
`endif
endmodule
